// File: rtl/fixed_point_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_point_multiplier
//  Brief    : Sequential shift-add unsigned Qm.f multiplier. It takes one
//             partial-product step per clock and saturates on overflow. It
//             uses the same start/busy/valid/ovf handshake as the fixed-point
//             divider.
//  Options  : MUL_ROUND_EN - when defined, rounds half-up when scaling the
//             result. When undefined, the result is truncated.
//  Revision : 1.0 - initial release
// ============================================================================
module fixed_point_multiplier #(
    parameter int WIDTH = 10,
    parameter int FRAC  = 6
) (
    input  logic             clk,
    input  logic             rst,     // asynchronous, active-low
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             valid,
    output logic             ovf
);

    // Step counter must reach WIDTH-1; one spare bit keeps it
    // unambiguous even when WIDTH is a power of two.
    localparam int                  c_CNT_W = $clog2(WIDTH) + 1;
    localparam int                  c_ACC_W = 2 * WIDTH;
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [c_ACC_W-1:0]   r_mcand;    // multiplicand, shifted left each step
    logic [WIDTH-1:0]     r_mplier;   // multiplier, shifted right each step
    logic [c_ACC_W-1:0]   r_acc;      // full-precision product
    logic [c_CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]     r_q;
    logic                 r_ovf;
    logic                 r_valid;
    logic                 r_busy;

    logic                 w_accept;
    logic [c_ACC_W:0]     w_sum;      // one extra bit absorbs a rounding carry
    logic [c_ACC_W:0]     w_scaled;
    logic                 w_over;
    logic [WIDTH-1:0]     w_q_next;

    assign w_accept = (r_state == S_IDLE) && start;

    // Add half an LSB of the output format before dropping the fractional
    // bits when rounding is enabled. Otherwise the product is truncated.
`ifdef MUL_ROUND_EN
    localparam logic [c_ACC_W:0] c_ROUND_HALF = (c_ACC_W + 1)'(1) << (FRAC - 1);
    assign w_sum = {1'b0, r_acc} + c_ROUND_HALF;
`else
    assign w_sum = {1'b0, r_acc};
`endif

    assign w_scaled = w_sum >> FRAC;
    assign w_over   = |w_scaled[c_ACC_W:WIDTH];
    assign w_q_next = w_over ? {WIDTH{1'b1}} : w_scaled[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: WIDTH steps in CALC, then one cycle in DONE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)           w_state_next = S_CALC;
            S_CALC:  if (r_cnt == c_LAST) w_state_next = S_DONE;
            S_DONE:                       w_state_next = S_IDLE;
            default:                      w_state_next = S_IDLE;
        endcase
    end

    // Shift-add datapath: capture operands on accept, one partial product per CALC cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, A};
            r_mplier <= B;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_CALC) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Handshake and result registers. busy lags the CALC state by one cycle,
    // so it covers the WIDTH cycles that end on the edge entering DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q     <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_busy  <= (r_state == S_CALC);
            r_valid <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_q   <= w_q_next;
                r_ovf <= w_over;
            end
        end
    end

    assign Q     = r_q;
    assign ovf   = r_ovf;
    assign valid = r_valid;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fixed_point_multiplier
//  Brief    : Directed self-checking bench for fixed_point_multiplier (Q4.6).
//             Expected results are hand-computed. Build with +define+MUL_ROUND_EN
//             to check the rounding build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_point_multiplier;

    localparam int WIDTH = 10;
    localparam int FRAC  = 6;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A     = '0;
    logic [WIDTH-1:0] B     = '0;
    logic [WIDTH-1:0] Q;
    logic             busy;
    logic             valid;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fixed_point_multiplier #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .busy  (busy),
        .valid (valid),
        .ovf   (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation. Optionally pulses a stray start during busy and
    // then watches for extra valid pulses.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_q, input logic exp_ovf, input bit inject);
        logic [WIDTH-1:0] q_before;
        logic             ovf_before;
        q_before   = Q;
        ovf_before = ovf;
        A     = a;
        B     = b;
        start = 1'b1;
        tick();                                   // accepting edge k
        start = 1'b0;
        A     = WIDTH'($urandom);                 // operands may change freely now
        B     = WIDTH'($urandom);
        check({tag, "_busy_k"},  32'(busy),  32'd0);
        check({tag, "_valid_k"}, 32'(valid), 32'd0);
        for (int i = 1; i <= WIDTH; i++) begin
            if (inject && i == 3) begin
                start = 1'b1;
                A     = 10'h080;
                B     = 10'h080;
            end
            tick();
            start = 1'b0;
            check({tag, "_busy"},   32'(busy),  32'd1);
            check({tag, "_valid0"}, 32'(valid), 32'd0);
            check({tag, "_qhold"},  32'(Q),     32'(q_before));
            check({tag, "_ohold"},  32'(ovf),   32'(ovf_before));
        end
        tick();                                   // edge k+WIDTH+1
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_busy0"}, 32'(busy),  32'd0);
        check({tag, "_q"},     32'(Q),     32'(exp_q));
        check({tag, "_ovf"},   32'(ovf),   32'(exp_ovf));
        tick();
        check({tag, "_pulse"}, 32'(valid), 32'd0);
        if (inject) begin
            for (int i = 0; i < WIDTH + 3; i++) begin
                tick();
                check({tag, "_noextra"}, 32'(valid), 32'd0);
                check({tag, "_qkeep"},   32'(Q),     32'(exp_q));
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_q",     32'(Q),     32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ovf",   32'(ovf),   32'd0);
        rst = 1'b1;
        tick();

        // 1.5 * 2.0 = 3.0
        run_op("basic", 10'h060, 10'h080, 10'h0C0, 1'b0, 1'b0);
        // 15.0 * 2.0 = 30.0 -> saturates
        run_op("ovf",   10'h3C0, 10'h080, 10'h3FF, 1'b1, 1'b0);
        // 1.0 * 1.0 = 1.0, overflow flag cleared
        run_op("clear", 10'h040, 10'h040, 10'h040, 1'b0, 1'b0);

        // Reset mid-operation: old Q (0x040) is cleared and the result is lost
        A     = 10'h060;
        B     = 10'h080;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check("mrst_busy",  32'(busy),  32'd0);
        check("mrst_valid", 32'(valid), 32'd0);
        check("mrst_q",     32'(Q),     32'd0);
        check("mrst_ovf",   32'(ovf),   32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < WIDTH + 3; i++) begin
            tick();
            check("mrst_novalid", 32'(valid), 32'd0);
            check("mrst_qzero",   32'(Q),     32'd0);
            check("mrst_busy0",   32'(busy),  32'd0);
        end
        run_op("fresh", 10'h060, 10'h080, 10'h0C0, 1'b0, 1'b0);

        // 2^-6 * 0.5: raw product 32, exactly half an output LSB
`ifdef MUL_ROUND_EN
        run_op("round", 10'h001, 10'h020, 10'h001, 1'b0, 1'b0);
`else
        run_op("round", 10'h001, 10'h020, 10'h000, 1'b0, 1'b0);
`endif

        // Zero operand, with a stray start during busy that must be dropped
        run_op("zero",  10'h000, 10'h3FF, 10'h000, 1'b0, 1'b1);

        // Back-to-back with start held high: the next accept is WIDTH+2 cycles after the last
        A     = 10'h080;
        B     = 10'h080;
        start = 1'b1;
        tick();                                   // accept
        repeat (WIDTH + 1) tick();
        check("b2b_valid1", 32'(valid), 32'd1);
        check("b2b_q1",     32'(Q),     32'h100);
        tick();                                   // re-accept, still high
        start = 1'b0;
        check("b2b_busy_k", 32'(busy), 32'd0);
        tick();
        check("b2b_busy",   32'(busy), 32'd1);
        repeat (WIDTH) tick();
        check("b2b_valid2", 32'(valid), 32'd1);
        check("b2b_q2",     32'(Q),     32'h100);
        check("b2b_ovf2",   32'(ovf),   32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fixed_point_multiplier.md
# fixed_point_multiplier

Sequential shift-add unsigned fixed-point multiplier, the inverse-operation companion to the team's fixed-point divider. It shares the divider's operand format and its start/busy/valid/ovf handshake, so the same controller or testbench can drive either unit. It computes Q = A × B in the same Qm.f format, saturating on overflow, with one partial-product step per clock.

## Interface
- WIDTH, 10: operand and result width in bits.
- FRAC, 6: fractional bits. The default format is Q4.6.
- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: request. Sampled only in IDLE.
- A, input, WIDTH: multiplicand. Captured on the accepting edge.
- B, input, WIDTH: multiplier. Captured on the accepting edge.
- Q, output, WIDTH: result register. Holds its value until the next completion.
- busy, output, 1: high while a multiplication is in progress.
- valid, output, 1: one-cycle pulse when Q and ovf are updated.
- ovf, output, 1: overflow flag for the current Q. Held alongside Q.

## Operation
- States:
  - IDLE: waits for start. On start=1 it captures A into the multiplicand register (2·WIDTH bits, zero-extended) and B into the multiplier register, clears the accumulator and the step counter, and goes to CALC.
  - CALC: runs WIDTH steps. Each step:
    - If the multiplier LSB is 1, add the multiplicand to the accumulator (2·WIDTH bits, no loss).
    - Shift the multiplicand left by 1 and the multiplier right by 1.
    - Increment the counter.
    - After step WIDTH−1, go to DONE.
  - DONE: forms the scaled result, loads Q and ovf, pulses valid, then returns to IDLE.
- Scaling: S = accumulator >> FRAC. If S > 2^WIDTH−1, then ovf=1 and Q = all ones (saturate). Otherwise ovf=0 and Q = S[WIDTH−1:0].
- Counter is ceil(log2(WIDTH))+1 bits wide. There is no early termination on zero operands.
- start is ignored in CALC and DONE. No queuing: a pulse seen there is dropped.
- A and B may change freely after the accepting edge.

## Timing
- Reset values: Q=0, busy=0, valid=0, ovf=0, state=IDLE. The accumulator, operand registers and counter are all 0.
- Start accepted at edge k:
  - busy=1 in the cycles after edges k+1 … k+WIDTH.
  - valid=1 in the single cycle after edge k+WIDTH+1, with busy=0 in that cycle.
- Latency: WIDTH+1 cycles from the accepting edge to valid. This is 11 cycles at the defaults.
- Q and ovf change only on the edge that raises valid. They are stable at all other times.
- A new start is accepted at the earliest one cycle after valid (back in IDLE).
- Reset asserted mid-operation:
  - Immediate return to reset values, with no valid pulse.
  - The aborted result is lost and the old Q is cleared to 0.
- start held high continuously: a new operation begins every WIDTH+2 cycles.

## Configuration
- MUL_ROUND_EN defined: round-half-up. The scaled result becomes S = (accumulator + 2^(FRAC−1)) >> FRAC. A carry from rounding that exceeds the range sets ovf and saturates.
- MUL_ROUND_EN undefined: truncation, S = accumulator >> FRAC.
- Latency and handshake are identical in both builds.

## Test plan
- Basic product: reset released, then A=0x060 (1.5) and B=0x080 (2.0) with a one-cycle start. Required: busy for 10 cycles, then valid for 1 cycle with Q=0x0C0 (3.0) and ovf=0.
- Overflow: A=0x3C0 (15.0), B=0x080 (2.0). Raw result 1920. Required: Q=0x3FF, ovf=1. Then run A=0x040, B=0x040, which must give Q=0x040 and ovf=0 (flag cleared).
- Rounding: A=0x001, B=0x020.
  - Without MUL_ROUND_EN: Q=0x000.
  - With MUL_ROUND_EN: Q=0x001.
  - ovf=0 in both builds.
- Zero and ignored start: A=0x000, B=0x3FF gives Q=0, valid at the 11th cycle. A second start pulsed during busy with A=B=0x080 must produce no extra valid, and Q stays 0.
- Reset mid-operation: start A=0x060, B=0x080, then drive rst low for 1 cycle at cycle 5. Required:
  - busy, valid, Q and ovf all 0 immediately, with no valid pulse afterwards.
  - A fresh start then completes normally with Q=0x0C0.
